apb_master_bridge: RTL

- Requester-side APB bridge: converts a simple valid/ready command stream (addr, write, wdata) into one APB transfer at a time on the master end of apb_intf.
- Returns each transfer's outcome (rdata, error, timeout) on a valid/ready response stream.
- Sits between internal initiators (test sequencers, CPU-side logic) and the APB fabric driving peripheral slaves.

---
 rtl/apb_pkg.sv | 41 ++++
 rtl/apb_wait_timer.sv | 44 ++++
 rtl/apb_master_bridge.sv | 129 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and per-state APB strobe encodings for the
//               requester-side APB bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Widest read data the response record carries; RD_WIDTH must not exceed it.
  localparam int c_rsp_rdata_w = 32;

  typedef struct packed {
    logic [c_rsp_rdata_w-1:0] rdata;
    logic                     err;
    logic                     timeout;
  } apb_rsp_t;

  // Bit n gives the strobe value while the FSM is in state n.
  localparam logic [3:0] c_psel_by_state    = 4'b0110;
  localparam logic [3:0] c_penable_by_state = 4'b0100;

  function automatic logic psel_of(input apb_state_e st);
    return c_psel_by_state[st];
  endfunction

  function automatic logic penable_of(input apb_state_e st);
    return c_penable_by_state[st];
  endfunction

endpackage : apb_pkg

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
// Module      : apb_wait_timer
// Description : Saturating ACCESS wait-state counter; flags the last cycle
//               allowed before the transfer is forcibly terminated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_pclk,
  input  logic preset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);
      localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(TIMEOUT);

      logic [c_cnt_w-1:0] r_cnt;

      always_ff @(posedge i_pclk) begin
        if (!preset_n || i_clear) begin
          r_cnt <= '0;
        end else if (i_enable && (r_cnt != c_max)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_expired = (r_cnt == c_last);
    end else begin : g_no_timer
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule : apb_wait_timer

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module      : apb_master_bridge
// Description : Converts a valid/ready command stream into single APB
//               transfers and returns each outcome on a response stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int A_WIDTH  = 32,
  parameter int WD_WIDTH = 32,
  parameter int RD_WIDTH = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                i_pclk,
  input  logic                preset_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [A_WIDTH-1:0]  i_cmd_addr,
  input  logic [WD_WIDTH-1:0] i_cmd_wdata,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [RD_WIDTH-1:0] o_rsp_rdata,
  output logic                o_rsp_err,
  output logic                o_rsp_timeout,
  output logic [A_WIDTH-1:0]  paddr,
  output logic                pwrite,
  output logic [WD_WIDTH-1:0] pwdata,
  output logic                psel,
  output logic                penable,
  input  logic [RD_WIDTH-1:0] prdata,
  input  logic                pready,
  input  logic                pslverr
);

  apb_state_e          r_state;
  apb_state_e          w_state_nxt;
  apb_rsp_t            r_rsp;
  apb_rsp_t            w_rsp_nxt;
  logic                w_capture;
  logic                w_expired;
  logic [A_WIDTH-1:0]  r_paddr;
  logic                r_pwrite;
  logic [WD_WIDTH-1:0] r_pwdata;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_pclk    (i_pclk),
    .preset_n  (preset_n),
    .i_clear   (r_state != ACCESS),
    .i_enable  ((r_state == ACCESS) && !pready),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_nxt   = r_rsp;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_state_nxt = SETUP;
          w_capture   = 1'b1;
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        // A completing slave always wins over a timeout in the same cycle.
        if (pready) begin
          w_state_nxt       = RESP;
          w_rsp_nxt.rdata   = r_pwrite ? '0 : c_rsp_rdata_w'(prdata);
          w_rsp_nxt.err     = pslverr;
          w_rsp_nxt.timeout = 1'b0;
        end else if (w_expired) begin
          w_state_nxt       = RESP;
          w_rsp_nxt.rdata   = '0;
          w_rsp_nxt.err     = 1'b1;
          w_rsp_nxt.timeout = 1'b1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (!preset_n) begin
      r_state  <= IDLE;
      r_rsp    <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rsp   <= w_rsp_nxt;
      if (w_capture) begin
        r_paddr  <= i_cmd_addr;
        r_pwrite <= i_cmd_write;
        r_pwdata <= i_cmd_wdata;
      end
    end
  end

  assign o_cmd_ready   = (r_state == IDLE) && preset_n;
  assign o_rsp_valid   = (r_state == RESP);
  assign o_rsp_rdata   = r_rsp.rdata[RD_WIDTH-1:0];
  assign o_rsp_err     = r_rsp.err;
  assign o_rsp_timeout = r_rsp.timeout;
  assign paddr         = r_paddr;
  assign pwrite        = r_pwrite;
  assign pwdata        = r_pwdata;
  assign psel          = psel_of(r_state);
  assign penable       = penable_of(r_state);

endmodule : apb_master_bridge

`default_nettype wire
